// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter: NUM_CORES requesters share one memory port,
// one transaction at a time, with a fixed number of wait states.
module multicore_mem_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        done,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        mrd,
  output logic                        mwr,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    sel_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_CORES-1:0] gnt_q;
  logic [NUM_CORES-1:0] done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mwdata_q;
  logic                mrd_q;
  logic                mwr_q;
  logic                busy_q;

  logic [ADDR_W-1:0] addr_a  [NUM_CORES];
  logic [DATA_W-1:0] wdata_a [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_split
    assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
  end

  // Walk offsets from far to near so the closest requester after
  // last_q overwrites any farther one.
  always_comb begin
    sel_d = last_q;
    for (int i = NUM_CORES; i >= 1; i--) begin
      int               j;
      logic [IDX_W-1:0] k;
      j = int'(last_q) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      k = IDX_W'(j);
      if (req[k]) sel_d = k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(NUM_CORES - 1);
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q  <= ACCESS;
            last_q   <= sel_d;
            cnt_q    <= CNT_W'(WAIT_CYCLES);
            gnt_q    <= NUM_CORES'(1) << sel_d;
            maddr_q  <= addr_a[sel_d];
            mwdata_q <= we[sel_d] ? wdata_a[sel_d] : '0;
            mrd_q    <= !we[sel_d];
            mwr_q    <= we[sel_d];
            busy_q   <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (mrd_q) rdata_q <= mem_rdata;
            state_q  <= RESP;
            done_q   <= gnt_q;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mrd       = mrd_q;
  assign mwr       = mwr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Random and directed bench for multicore_mem_arbiter against a
// transaction-level reference model.
module tb_multicore_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req, we, gnt, done;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_rdata, mem_wdata;
  logic [AW-1:0]   mem_addr;
  logic            mrd, mwr, busy;

  logic [N-1:0]    req0, we0, gnt0, done0;
  logic [N*AW-1:0] addr0;
  logic [N*DW-1:0] wdata0;
  logic [DW-1:0]   rdata0, mem_rdata0, mem_wdata0;
  logic [AW-1:0]   mem_addr0;
  logic            mrd0, mwr0, busy0;

  logic            mem_sel = 1'b0;
  logic [DW-1:0]   mem_fix = '0;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return mem_sel ? mem_fix : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  assign mem_rdata  = mem_f(mem_addr);
  assign mem_rdata0 = mem_addr0 ^ 32'h13579BDF;

  multicore_mem_arbiter #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mrd(mrd), .mwr(mwr), .busy(busy)
  );

  multicore_mem_arbiter #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0),
    .addr(addr0), .wdata(wdata0), .gnt(gnt0), .done(done0),
    .rdata(rdata0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .mrd(mrd0), .mwr(mwr0), .busy(busy0)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Reference model: m_t counts cycles since the grant edge
  // (0 = no transaction in flight).
  int            m_t, m_k, m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;

  task automatic m_reset();
    m_t = 0; m_k = 0; m_last = N - 1; m_rd = '0;
  endtask

  task automatic m_step();
    if (m_t == 0) begin
      if (req != '0) begin
        bit found = 0;
        for (int i = 1; i <= N; i++) begin
          int j = (m_last + i) % N;
          if (!found && req[j]) begin m_k = j; found = 1; end
        end
        m_last = m_k;
        m_we   = we[m_k];
        m_addr = addr[m_k*AW +: AW];
        m_wd   = wdata[m_k*DW +: DW];
        m_t    = 1;
      end
    end else if (m_t == W + 2) begin
      m_t = 0;
    end else begin
      if (m_t == W + 1 && !m_we) m_rd = mem_f(m_addr);
      m_t++;
    end
  endtask

  task automatic check_out();
    logic [N-1:0]  eg, ed;
    logic          emr, emw, eb;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    eg = '0; ed = '0; emr = 0; emw = 0; eb = 0; ea = '0; ew = '0;
    if (m_t > 0) begin eg = N'(1) << m_k; eb = 1; end
    if (m_t >= 1 && m_t <= W + 1) begin
      emr = !m_we; emw = m_we; ea = m_addr;
      ew = m_we ? m_wd : '0;
    end
    if (m_t == W + 2) ed = eg;
    chk("gnt", gnt, eg);
    chk("done", done, ed);
    chk("mrd", mrd, emr);
    chk("mwr", mwr, emw);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("busy", busy, eb);
    chk("rdata", rdata, m_rd);
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  logic [N-1:0] pg;
  logic [N-1:0] pend;
  int           wt[N];
  int           gq[$];
  int           dq[$];
  int           cyc_n;

  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_out();
    cyc_n++;
    if (gnt != '0 && pg == '0) begin
      int g = oh2i(gnt);
      gq.push_back(g);
      chk("starve", wt[g] <= N - 1, 1);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) wt[i] = 0;
        else if (i != g) wt[i]++;
      end
      wt[g] = 0;
    end
    pg = gnt;
    if (done != '0) dq.push_back(cyc_n);
  endtask

  task automatic clr_book();
    pg = '0; pend = '0; cyc_n = 0;
    gq.delete(); dq.delete();
    for (int i = 0; i < N; i++) wt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    m_reset();
    clr_book();
    #1;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stim();
    for (int i = 0; i < N; i++) begin
      if (m_t == W + 2 && m_k == i) pend[i] = 1'b0;
      if (m_t >= 1 && m_t <= W + 1 && m_k == i) begin
        if ($urandom_range(0, 1) == 1) begin
          req[i] = 1'($urandom_range(0, 1));
          we[i]  = 1'($urandom_range(0, 1));
          addr[i*AW +: AW]  = $urandom();
          wdata[i*DW +: DW] = $urandom();
        end
      end else if (!pend[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          req[i]  = 1'b1;
          we[i]   = 1'($urandom_range(0, 1));
          addr[i*AW +: AW]  = $urandom();
          wdata[i*DW +: DW] = $urandom();
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  int nmrd, nmwr;
  int dq0[$];

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0;
    req0 = '0; we0 = '0; addr0 = '0; wdata0 = '0;
    m_reset();
    clr_book();

    // single read from core 2
    do_reset();
    mem_sel = 1'b1;
    mem_fix = 32'hDEADBEEF;
    req = 4'b0100;
    addr[2*AW +: AW] = 32'h100;
    nmrd = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (mrd) nmrd++;
      if (m_t == W + 2) req = '0;
    end
    chk("rd_mrd_cycles", nmrd, 3);
    chk("rd_data", rdata, 32'hDEADBEEF);

    // write from core 1 leaves rdata alone
    req = 4'b0010; we = 4'b0010;
    addr[1*AW +: AW]  = 32'h40;
    wdata[1*DW +: DW] = 32'hCAFEF00D;
    nmrd = 0; nmwr = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (mrd) nmrd++;
      if (mwr) nmwr++;
      if (m_t == W + 2) req = '0;
    end
    chk("wr_mwr_cycles", nmwr, 3);
    chk("wr_mrd_cycles", nmrd, 0);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    mem_sel = 1'b0;

    // all four requesting from reset
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = 32'h1000 + i;
    repeat (21) cyc();
    chk("rr4_cnt", gq.size(), 5);
    for (int i = 0; i < gq.size() && i < 5; i++)
      chk("rr4_order", gq[i], i % N);
    chk("rr4_done_cnt", dq.size(), 4);
    for (int i = 1; i < dq.size(); i++)
      chk("rr4_period", dq[i] - dq[i-1], 5);

    // fairness between cores 0 and 3
    do_reset();
    req = 4'b1001;
    repeat (20) cyc();
    chk("fair_cnt", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++)
      chk("fair_order", gq[i], (i % 2 == 0) ? 0 : 3);

    // reset in the second ACCESS cycle of core 2
    do_reset();
    req = 4'b0100;
    addr[2*AW +: AW] = 32'h200;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    m_reset();
    clr_book();
    #1;
    chk("rst_mrd", mrd, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    check_out();
    @(negedge clk);
    req = 4'b0110;
    rst_n = 1'b1;
    cyc();
    chk("rst_first", gnt, 4'b0010);
    req = '0;
    repeat (6) cyc();

    // random traffic
    do_reset();
    repeat (3000) begin
      stim();
      cyc();
    end
    req = '0;
    repeat (10) cyc();

    // zero wait-state instance
    @(negedge clk);
    req0 = 4'b0100;
    addr0[2*AW +: AW] = 32'h200;
    @(posedge clk); @(negedge clk);
    chk("w0_gnt", gnt0, 4'b0100);
    chk("w0_mrd_on", mrd0, 1);
    chk("w0_addr", mem_addr0, 32'h200);
    chk("w0_done_early", done0, 0);
    @(posedge clk); @(negedge clk);
    chk("w0_mrd_off", mrd0, 0);
    chk("w0_done", done0, 4'b0100);
    chk("w0_rdata", rdata0, 32'h200 ^ 32'h13579BDF);
    req0 = '0;
    @(posedge clk); @(negedge clk);
    chk("w0_busy_off", busy0, 0);
    chk("w0_done_off", done0, 0);
    req0 = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (done0 != '0) dq0.push_back(c);
    end
    req0 = '0;
    chk("w0_done_cnt", dq0.size(), 4);
    for (int i = 1; i < dq0.size(); i++)
      chk("w0_period", dq0[i] - dq0[i-1], 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicore_mem_arbiter.md
MULTICORE_MEM_ARBITER -- requirements
Module: multicore_mem_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
- NUM_CORES, default 4: number of requesting SubCores, range 2..16.
- ADDR_W, default 32: memory address width.
- DATA_W, default 32: memory data width.
- WAIT_CYCLES, default 2: extra memory wait states per access, range 0..15.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- req, in, NUM_CORES: per-core access request.
- we, in, NUM_CORES: per-core write flag (1=write, 0=read).
- addr, in, NUM_CORES*ADDR_W: per-core address; core i occupies slice [i*ADDR_W +: ADDR_W].
- wdata, in, NUM_CORES*DATA_W: per-core write data; same slicing as addr.
- gnt, out, NUM_CORES: one-hot grant.
- done, out, NUM_CORES: one-hot, one-cycle completion pulse.
- rdata, out, DATA_W: last completed read data.
- mem_addr, out, ADDR_W: shared memory address.
- mem_wdata, out, DATA_W: shared memory write data.
- mem_rdata, in, DATA_W: shared memory read data.
- mrd, out, 1: memory read strobe.
- mwr, out, 1: memory write strobe.
- busy, out, 1: arbiter not in IDLE.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, ACCESS and RESP, with all outputs registered.

REQ-004 In IDLE, if req is nonzero at a clock edge, the block SHALL do all of the following at that edge:
- Select index k by round-robin, searching from last_gnt+1 upward with wrap-around.
- Latch addr[k], we[k] and wdata[k].
- Set gnt to one-hot k, set last_gnt to k, load cnt with WAIT_CYCLES, and enter ACCESS.

REQ-005 In IDLE with req equal to zero, the block SHALL remain in IDLE with all outputs unchanged.

REQ-006 In ACCESS, the block SHALL drive mem_addr with the latched address and hold mrd=!we_l and mwr=we_l high.

REQ-007 In ACCESS, mem_wdata SHALL equal the latched wdata for a write and 0 for a read.

REQ-008 At each edge in ACCESS, the block SHALL:
- If cnt==0: capture mem_rdata into rdata (reads only) and enter RESP.
- Otherwise: decrement cnt.

REQ-009 ACCESS SHALL therefore last exactly WAIT_CYCLES+1 cycles, and mrd/mwr SHALL never both be high.

REQ-010 In RESP, the block SHALL:
- Drive done to one-hot k for exactly one cycle.
- Drive mrd, mwr, mem_addr and mem_wdata to 0.
- Keep gnt asserted.
- Return to IDLE at the next edge, clearing gnt.

REQ-011 End-to-end latency: with a request sampled at edge E0, done SHALL be high during the cycle after edge E0+WAIT_CYCLES+1.

REQ-012 Back-to-back transactions SHALL occupy WAIT_CYCLES+3 cycles each, including one mandatory IDLE cycle.

REQ-013 A requester SHALL hold req, we, addr and wdata stable until its done pulse.

REQ-014 Deasserting req after grant SHALL NOT abort the transaction, and changes to any input during ACCESS SHALL be ignored.

REQ-015 rdata SHALL hold its value until the next completed read; writes SHALL NOT modify rdata.

REQ-016 busy SHALL be 1 in ACCESS and RESP and 0 in IDLE.

REQ-017 cnt SHALL be $clog2(WAIT_CYCLES+1) bits wide with a minimum of 1 bit, and WAIT_CYCLES=0 SHALL give a single-cycle ACCESS.

REQ-018 Arbitration SHALL be starvation-free: a continuously asserted req SHALL be granted within NUM_CORES-1 intervening transactions.

Reset
REQ-019 When rst_n goes low, the block SHALL immediately and asynchronously:
- Enter IDLE.
- Clear gnt, done, rdata, mem_addr, mem_wdata, mrd, mwr, busy and cnt to 0.
- Set last_gnt to NUM_CORES-1, so core 0 has first priority.

REQ-020 Reset asserted during ACCESS or RESP SHALL abort the transaction with no done pulse.

REQ-021 After rst_n deasserts, the first edge SHALL be able to accept a request.

Verification (NUM_CORES=4, ADDR_W=DATA_W=32, WAIT_CYCLES=2 unless noted)
REQ-022 Single read:
- Stimulus: req=0100, we=0, addr[2]=0x100, mem_rdata=0xDEADBEEF.
- Response: gnt=0100 one cycle after the request edge; mrd high for 3 cycles with mem_addr=0x100; done=0100 for 1 cycle; rdata=0xDEADBEEF; busy falls one cycle after done.

REQ-023 Write:
- Stimulus: core 1 writes 0xCAFEF00D to 0x40.
- Response: mwr high for 3 cycles with mem_wdata=0xCAFEF00D; mrd stays 0; done=0010; rdata unchanged.

REQ-024 Simultaneous requests after reset:
- Stimulus: req=1111 held continuously.
- Response: grant order 0,1,2,3,0; one done pulse every 5 cycles.

REQ-025 Fairness:
- Stimulus: req=1001 held continuously, starting from reset.
- Response: grants alternate 0,3,0,3; core 3 is never skipped twice.

REQ-026 Reset mid-ACCESS:
- Stimulus: rst_n low in the second ACCESS cycle of core 2.
- Response: mrd, gnt and busy drop to 0 without waiting for a clock edge; no done pulse; after release with req=0110, core 1 is granted first.

REQ-027 WAIT_CYCLES=0:
- Stimulus: a single read.
- Response: mrd high for 1 cycle; done in the second cycle after the request edge; back-to-back period of 3 cycles.
